alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered result/condition-code stage directly downstream of the `addr1r2r3` adder. It captures the adder's combinational sum and NZCV flags into a small in-order FIFO. It hands each entry to register-file writeback over a valid/ready handshake. It maintains the architectural condition-code register, which is updated only when a flag-setting entry retires.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; matches adder `r1`.
- `REGW`, 5, destination register index width.
- `DEPTH`, 2, FIFO entries; legal values 2 or 4.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an adder result is presented this cycle.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `in_r1`  in  WIDTH  adder sum `r1`.
- `in_n`, `in_z`, `in_c`, `in_v`  in  1 each  adder flags.
- `in_rd`  in  REGW  destination register index.
- `in_setf`  in  1  entry updates condition codes on retire.
- `wb_valid`  out  1  head entry is available for writeback.
- `wb_ready`  in  1  writeback consumes the head entry.
- `wb_data`  out  WIDTH  head entry sum.
- `wb_rd`  out  REGW  head entry destination.
- `flags`  out  4  condition-code register, ordered {N,Z,C,V}.
- `count`  out  3  current FIFO occupancy, 0..DEPTH.
- `retired`  out  16  count of retired entries; wraps modulo 2^16.

## Operation
- Push: on an edge where `in_valid && in_ready`, store {in_r1, in_n, in_z, in_c, in_v, in_rd, in_setf} at the tail.
- Pop: on an edge where `wb_valid && wb_ready`, remove the head entry. This is a retire.
- Combinational outputs: `in_ready = (count < DEPTH)`; `wb_valid = (count != 0)`; `wb_data`/`wb_rd` = head entry fields.
- When `wb_valid=0`, `wb_data` and `wb_rd` hold the last popped values, or 0 after reset.
- `in_ready` must not depend on `wb_ready` in the same cycle. When full, `in_ready=0` even if a pop occurs that cycle.
- Condition codes: on a retire with head `setf=1`, `flags` <= head {n,z,c,v}. A retire with `setf=0` leaves `flags` unchanged.
- Flags are never updated at push time, and never by an entry that has not retired.
- `retired` increments by 1 on every retire and wraps 0xFFFF -> 0x0000.
- Entries retire strictly in push order. Pointers wrap modulo DEPTH.
- Flag and data fields are stored verbatim; the stage performs no arithmetic on them.
- Internal state: `head` ptr, `tail` ptr, `count`, entry array, `flags` register, `retired` counter. Occupancy states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).

## Timing
- Reset: while `reset=1` at an edge, set count=0, head=tail=0, flags=4'b0000, retired=0, wb_data=0, wb_rd=0.
- Push and pop inputs are ignored while `reset=1`.
- Reset mid-operation discards all queued entries without retiring them; `flags` returns to 0.
- Latency: an entry pushed at edge k has `wb_valid=1` in the cycle after edge k, at the earliest.
- No combinational path from `in_*` to `wb_*`.
- `flags` and `retired` reflect a retire at edge k from the cycle after edge k.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged; both pointers advance.
- Push when EMPTY with `wb_ready=1`: the entry is not bypassed; it pops at the next edge at the earliest.
- Full: the upstream producer must hold `in_*` stable until `in_ready=1`.
- `wb_ready` held low: all outputs stable, and `flags` frozen.

## Test plan
- Reset, then push r1=0x00000002 {N,Z,C,V}=0000, rd=3, setf=1 with wb_ready=1 -> next cycle wb_valid=1, wb_data=0x00000002, wb_rd=3; after that retire flags=0000, retired=1.
- Push sum 0x00000000 with flags 0111 (0x80000000+0x80000000), setf=1; then push 0x80000000 with flags 1001 (0x40000000+0x40000000), setf=0 -> flags=0111 after the first retire and stays 0111 after the second.
- wb_ready=0, push 3 entries back-to-back with DEPTH=2 -> in_ready falls after the 2nd push, count=2, and the 3rd value is held; raise wb_ready -> wb_data sequence matches push order with no loss.
- Continuous push and pop with count=1 for 10 cycles -> count stays 1, and `retired` advances by 1 per cycle.
- Assert reset with count=2 and flags=1001 -> next cycle count=0, wb_valid=0, flags=0000, retired=0; queued entries never appear on wb_*.
- Retire 65536 entries -> `retired` wraps to 0x0000.

Source files
------------

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Registered result / condition-code stage that sits after the addr1r2r3 adder.
// Each adder result (sum + NZCV + destination + set-flags bit) is captured into
// a small in-order FIFO and handed to register-file writeback over valid/ready.
// The architectural condition-code register only changes when a flag-setting
// entry retires (is popped by writeback).
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake; in_ready depends only on occupancy
//   in_r1, in_n..in_v     adder sum and flags, stored verbatim
//   in_rd, in_setf        destination index, flag-update enable for this entry
//   wb_valid / wb_ready   writeback handshake for the head entry
//   wb_data, wb_rd        head entry fields (last popped values when empty)
//   flags                 condition-code register {N,Z,C,V}
//   count                 FIFO occupancy 0..DEPTH
//   retired               retire counter, wraps modulo 2^16
// -----------------------------------------------------------------------------
module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5,
   parameter int DEPTH = 2      // 2 or 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_r1,
   input  logic             in_n,
   input  logic             in_z,
   input  logic             in_c,
   input  logic             in_v,
   input  logic [REGW-1:0]  in_rd,
   input  logic             in_setf,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [WIDTH-1:0] wb_data,
   output logic [REGW-1:0]  wb_rd,
   output logic [3:0]       flags,
   output logic [2:0]       count,
   output logic [15:0]      retired
);

   localparam int PW = (DEPTH > 2) ? 2 : 1;
   localparam logic [2:0] DEPTH_C = 3'(DEPTH);

   typedef logic [PW-1:0] ptr_t;

   typedef struct packed {
      logic [WIDTH-1:0] r1;
      logic [3:0]       f;     // {N,Z,C,V}
      logic [REGW-1:0]  rd;
      logic             setf;
   } entry_t;

   entry_t           mem_q [DEPTH];
   ptr_t             head_q, tail_q;
   logic [2:0]       count_q, count_d;
   logic [3:0]       flags_q;
   logic [15:0]      retired_q;
   logic [WIDTH-1:0] last_data_q;
   logic [REGW-1:0]  last_rd_q;

   logic   push, pop;
   entry_t in_ent, head_ent;

   // in_ready looks only at registered occupancy: a full FIFO refuses a push
   // even when writeback drains it in the same cycle, so no ready->ready path.
   assign in_ready = (count_q < DEPTH_C);
   assign wb_valid = (count_q != 3'd0);
   assign push     = in_valid && in_ready;
   assign pop      = wb_valid && wb_ready;

   assign in_ent   = '{r1: in_r1, f: {in_n, in_z, in_c, in_v}, rd: in_rd, setf: in_setf};
   assign head_ent = mem_q[head_q];

   // When empty, writeback outputs keep showing the last retired entry.
   assign wb_data  = wb_valid ? head_ent.r1 : last_data_q;
   assign wb_rd    = wb_valid ? head_ent.rd : last_rd_q;
   assign flags    = flags_q;
   assign count    = count_q;
   assign retired  = retired_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;   // idle, or push+pop cancel out
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         flags_q     <= '0;
         retired_q   <= '0;
         last_data_q <= '0;
         last_rd_q   <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            mem_q[tail_q] <= in_ent;
            tail_q        <= tail_q + ptr_t'(1);
         end
         if (pop) begin
            head_q      <= head_q + ptr_t'(1);
            last_data_q <= head_ent.r1;
            last_rd_q   <= head_ent.rd;
            retired_q   <= retired_q + 16'd1;
            if (head_ent.setf)
               flags_q <= head_ent.f;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//
// Directed scenarios followed by randomized traffic. Expected outputs come
// from a queue-based reference model of the stage's retire/flag rules.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

   localparam int WIDTH = 32;
   localparam int REGW  = 5;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_r1;
   logic             in_n, in_z, in_c, in_v;
   logic [REGW-1:0]  in_rd;
   logic             in_setf;
   logic             wb_valid;
   logic             wb_ready;
   logic [WIDTH-1:0] wb_data;
   logic [REGW-1:0]  wb_rd;
   logic [3:0]       flags;
   logic [2:0]       count;
   logic [15:0]      retired;

   alu_result_stage #(.WIDTH(WIDTH), .REGW(REGW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_r1(in_r1), .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
      .in_rd(in_rd), .in_setf(in_setf),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_data(wb_data), .wb_rd(wb_rd),
      .flags(flags), .count(count), .retired(retired)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [WIDTH-1:0] r1;
      logic [3:0]       f;
      logic [REGW-1:0]  rd;
      logic             setf;
   } ent_t;

   ent_t             q[$];
   logic [3:0]       m_flags;
   logic [15:0]      m_retired;
   logic [WIDTH-1:0] m_last_data;
   logic [REGW-1:0]  m_last_rd;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Compare every output with the model, then advance one clock.
   task automatic tick(input bit check = 1'b1);
      bit pu, po;
      ent_t e;
      if (check) begin
         chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
         chk("wb_valid", 32'(wb_valid), 32'(q.size() != 0));
         chk("wb_data",  wb_data, (q.size() != 0) ? q[0].r1 : m_last_data);
         chk("wb_rd",    32'(wb_rd), 32'((q.size() != 0) ? q[0].rd : m_last_rd));
         chk("flags",    32'(flags), 32'(m_flags));
         chk("count",    32'(count), 32'(q.size()));
         chk("retired",  32'(retired), 32'(m_retired));
      end
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_flags = 4'd0; m_retired = 16'd0; m_last_data = '0; m_last_rd = '0;
      end else begin
         pu = in_valid && (q.size() < DEPTH);
         po = wb_ready && (q.size() != 0);
         if (po) begin
            e = q.pop_front();
            m_last_data = e.r1;
            m_last_rd   = e.rd;
            m_retired   = m_retired + 16'd1;
            if (e.setf) m_flags = e.f;
         end
         if (pu) begin
            e.r1 = in_r1; e.f = {in_n, in_z, in_c, in_v}; e.rd = in_rd; e.setf = in_setf;
            q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] r1, input logic [3:0] f,
                        input logic [REGW-1:0] rd, input logic sf);
      in_valid = v; in_r1 = r1; {in_n, in_z, in_c, in_v} = f; in_rd = rd; in_setf = sf;
   endtask

   initial begin
      reset = 1'b1; wb_ready = 1'b0;
      drive(1'b0, 32'd0, 4'd0, '0, 1'b0);
      m_flags = 4'd0; m_retired = 16'd0; m_last_data = '0; m_last_rd = '0;
      tick(1'b0); tick(1'b0);
      reset = 1'b0;

      // reset state
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_wbv",   32'(wb_valid), 32'd0);
      chk("rst_data",  wb_data, 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);

      // single push, no bypass, then retire
      wb_ready = 1'b1;
      drive(1'b1, 32'h2, 4'b0000, 5'd3, 1'b1);
      chk("p1_nobypass", 32'(wb_valid), 32'd0);
      tick();
      drive(1'b0, 32'h0, 4'd0, '0, 1'b0);
      chk("p1_wbv",  32'(wb_valid), 32'd1);
      chk("p1_data", wb_data, 32'h2);
      chk("p1_rd",   32'(wb_rd), 32'd3);
      tick();
      chk("p1_flags",   32'(flags), 32'd0);
      chk("p1_retired", 32'(retired), 32'd1);
      chk("p1_hold",    wb_data, 32'h2);

      // setf=0 retire must not disturb flags
      wb_ready = 1'b0;
      drive(1'b1, 32'h0, 4'b0111, 5'd4, 1'b1);        tick();
      drive(1'b1, 32'h8000_0000, 4'b1001, 5'd5, 1'b0); tick();
      drive(1'b0, 32'h0, 4'd0, '0, 1'b0);
      chk("f_held", 32'(flags), 32'd0);
      tick(); tick();                                  // frozen while wb_ready=0
      wb_ready = 1'b1;
      tick();
      chk("f_first", 32'(flags), 32'b0111);
      tick();
      chk("f_second", 32'(flags), 32'b0111);
      chk("f_retired", 32'(retired), 32'd3);

      // backpressure: three pushes into a 2-deep FIFO
      wb_ready = 1'b0;
      drive(1'b1, 32'hA0, 4'd1, 5'd10, 1'b0); tick();
      drive(1'b1, 32'hB0, 4'd2, 5'd11, 1'b0); tick();
      drive(1'b1, 32'hC0, 4'd3, 5'd12, 1'b0);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_count", 32'(count), 32'd2);
      tick(); tick();
      chk("bp_head", wb_data, 32'hA0);
      wb_ready = 1'b1;
      tick();                                          // pop A, C still refused
      chk("bp_second", wb_data, 32'hB0);
      tick();                                          // pop B, push C
      drive(1'b0, 32'h0, 4'd0, '0, 1'b0);
      chk("bp_third", wb_data, 32'hC0);
      tick();
      chk("bp_empty", 32'(count), 32'd0);

      // steady state: push and pop every cycle at count=1
      wb_ready = 1'b0;
      drive(1'b1, 32'h100, 4'd0, 5'd1, 1'b0); tick();
      wb_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h101 + 32'(i), 4'd0, 5'(i), 1'b0);
         chk("ss_count", 32'(count), 32'd1);
         tick();
      end
      drive(1'b0, 32'h0, 4'd0, '0, 1'b0);
      chk("ss_retired", 32'(retired), 32'd16);
      tick();

      // reset mid-operation with count=2 and flags=1001
      drive(1'b1, 32'h55, 4'b1001, 5'd7, 1'b1); tick();
      drive(1'b0, 32'h0, 4'd0, '0, 1'b0); tick();
      wb_ready = 1'b0;
      drive(1'b1, 32'h66, 4'b0110, 5'd8, 1'b1); tick();
      drive(1'b1, 32'h77, 4'b1111, 5'd9, 1'b1); tick();
      chk("mr_count", 32'(count), 32'd2);
      chk("mr_flags", 32'(flags), 32'b1001);
      reset = 1'b1; wb_ready = 1'b1;                   // push/pop ignored under reset
      tick();
      reset = 1'b0;
      drive(1'b0, 32'h0, 4'd0, '0, 1'b0);
      chk("mr_count0", 32'(count), 32'd0);
      chk("mr_wbv",    32'(wb_valid), 32'd0);
      chk("mr_flags0", 32'(flags), 32'd0);
      chk("mr_ret0",   32'(retired), 32'd0);
      chk("mr_data0",  wb_data, 32'd0);
      tick(); tick();

      // randomized traffic; producer holds inputs while refused
      for (int i = 0; i < 400; i++) begin
         if (!(in_valid && q.size() >= DEPTH))
            drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom), 5'($urandom), 1'($urandom));
         wb_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) reset = 1'b1;
         tick();
         reset = 1'b0;
      end

      // retire counter wrap: 65536 retires after one priming push
      reset = 1'b1; tick(1'b0); reset = 1'b0;
      wb_ready = 1'b1;
      for (int i = 0; i <= 65536; i++) begin
         drive(1'b1, 32'(i), 4'(i), 5'(i), 1'(i));
         tick(i < 64 || i > 65500);
      end
      drive(1'b0, 32'h0, 4'd0, '0, 1'b0);
      chk("wrap_retired", 32'(retired), 32'd0);
      tick();
      chk("wrap_after", 32'(retired), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
